// File: rtl/alu_cmd_queue.sv
// Command/result buffering around a registered two-stage ALU: commands queue in a FIFO,
// issue under a 4-credit limit, and their results return in order through a 4-entry FIFO.
module alu_cmd_queue #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_mode,
    input  logic [WIDTH:0]   alu_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_y,
    output logic [1:0]       out_mode,
    output logic             idle
);

    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = $clog2(DEPTH + 1);
    localparam int CMD_W     = 2 * WIDTH + 2;
    localparam int RES_W     = WIDTH + 3;
    localparam int RES_DEPTH = 4;

    logic [CMD_W-1:0] cmd_mem_q [DEPTH];
    logic [CMD_W-1:0] cmd_mem_d [DEPTH];
    logic [AW-1:0]    cmd_wr_ptr_q, cmd_wr_ptr_d;
    logic [AW-1:0]    cmd_rd_ptr_q, cmd_rd_ptr_d;
    logic [CW-1:0]    cmd_count_q, cmd_count_d;

    logic [RES_W-1:0] res_mem_q [RES_DEPTH];
    logic [RES_W-1:0] res_mem_d [RES_DEPTH];
    logic [1:0]       res_wr_ptr_q, res_wr_ptr_d;
    logic [1:0]       res_rd_ptr_q, res_rd_ptr_d;
    logic [2:0]       res_count_q, res_count_d;

    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_mode_q, alu_mode_d;
    logic             p1_q, p1_d;
    logic             p2_q, p2_d;
    logic [1:0]       p1_mode_q, p1_mode_d;
    logic [1:0]       p2_mode_q, p2_mode_d;

    logic             cmd_empty;
    logic             cmd_full;
    logic             res_empty;
    logic             cmd_push;
    logic             issue;
    logic             res_push;
    logic             res_pop;
    logic [2:0]       credit_used;
    logic [CMD_W-1:0] cmd_head;
    logic [RES_W-1:0] res_head;

    assign cmd_empty = (cmd_count_q == '0);
    assign cmd_full  = (cmd_count_q == CW'(DEPTH));
    assign res_empty = (res_count_q == 3'd0);
    assign cmd_head  = cmd_mem_q[cmd_rd_ptr_q];
    assign res_head  = res_mem_q[res_rd_ptr_q];

    assign in_ready  = !cmd_full;
    assign out_valid = !res_empty;
    assign out_y     = res_head[WIDTH:0];
    assign out_mode  = res_head[WIDTH+2:WIDTH+1];
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_mode  = alu_mode_q;
    assign idle      = cmd_empty && !p1_q && !p2_q && res_empty;

    // Results held plus commands in the ALU pipe may never exceed the result FIFO size.
    assign credit_used = res_count_q + {2'b00, p1_q} + {2'b00, p2_q};
    assign cmd_push    = in_valid && in_ready;
    assign issue       = !cmd_empty && (credit_used < 3'd4);
    assign res_push    = p2_q;
    assign res_pop     = out_valid && out_ready;

    always_comb begin
        cmd_mem_d = cmd_mem_q;
        if (cmd_push) begin
            cmd_mem_d[cmd_wr_ptr_q] = {in_mode, in_a, in_b};
        end
        cmd_wr_ptr_d = cmd_wr_ptr_q + AW'(cmd_push);
        cmd_rd_ptr_d = cmd_rd_ptr_q + AW'(issue);
        cmd_count_d  = cmd_count_q + CW'(cmd_push) - CW'(issue);
    end

    always_comb begin
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_mode_d = alu_mode_q;
        p1_mode_d  = p1_mode_q;
        if (issue) begin
            alu_b_d    = cmd_head[WIDTH-1:0];
            alu_a_d    = cmd_head[2*WIDTH-1:WIDTH];
            alu_mode_d = cmd_head[2*WIDTH+1:2*WIDTH];
            p1_mode_d  = cmd_head[2*WIDTH+1:2*WIDTH];
        end
        p1_d      = issue;
        p2_d      = p1_q;
        p2_mode_d = p1_mode_q;
    end

    always_comb begin
        res_mem_d = res_mem_q;
        if (res_push) begin
            res_mem_d[res_wr_ptr_q] = {p2_mode_q, alu_y};
        end
        res_wr_ptr_d = res_wr_ptr_q + 2'(res_push);
        res_rd_ptr_d = res_rd_ptr_q + 2'(res_pop);
        res_count_d  = res_count_q + 3'(res_push) - 3'(res_pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                cmd_mem_q[i] <= '0;
            end
            for (int i = 0; i < RES_DEPTH; i++) begin
                res_mem_q[i] <= '0;
            end
            cmd_wr_ptr_q <= '0;
            cmd_rd_ptr_q <= '0;
            cmd_count_q  <= '0;
            res_wr_ptr_q <= '0;
            res_rd_ptr_q <= '0;
            res_count_q  <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_mode_q   <= '0;
            p1_q         <= 1'b0;
            p2_q         <= 1'b0;
            p1_mode_q    <= '0;
            p2_mode_q    <= '0;
        end else begin
            cmd_mem_q    <= cmd_mem_d;
            res_mem_q    <= res_mem_d;
            cmd_wr_ptr_q <= cmd_wr_ptr_d;
            cmd_rd_ptr_q <= cmd_rd_ptr_d;
            cmd_count_q  <= cmd_count_d;
            res_wr_ptr_q <= res_wr_ptr_d;
            res_rd_ptr_q <= res_rd_ptr_d;
            res_count_q  <= res_count_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_mode_q   <= alu_mode_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            p1_mode_q    <= p1_mode_d;
            p2_mode_q    <= p2_mode_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Bench for alu_cmd_queue: a behavioural registered ALU closes the loop, and a queue of
// expected results (computed at accept time) scores every delivered result.
module tb_alu_cmd_queue;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a, in_b;
    logic [1:0]       in_mode;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [1:0]       alu_mode;
    logic [WIDTH:0]   alu_y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_y;
    logic [1:0]       out_mode;
    logic             idle;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_pop = 0;
    logic           last_pop;
    logic [WIDTH:0] last_y;
    logic [WIDTH+2:0] exp_q[$];

    always #5 clk = ~clk;

    alu_cmd_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_y(alu_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_mode(out_mode), .idle(idle)
    );

    // Registered ALU stage the queue feeds.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) alu_y <= '0;
        else begin
            case (alu_mode)
                2'd0:    alu_y <= {1'b0, alu_a} + {1'b0, alu_b};
                2'd1:    alu_y <= {1'b0, alu_a} - {1'b0, alu_b};
                2'd2:    alu_y <= {1'b0, alu_a} + 5'd1;
                default: alu_y <= {1'b0, alu_b} + 5'd1;
            endcase
        end
    end

    function automatic logic [WIDTH:0] ref_y(input int a, input int b, input int m);
        int r;
        case (m)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a + 1;
            default: r = b + 1;
        endcase
        r = ((r % 32) + 32) % 32;
        return r[WIDTH:0];
    endfunction

    // One clock: handshakes sampled before the edge, model updated after it.
    task automatic tick();
        logic acc, pp;
        logic [WIDTH:0] y;
        logic [1:0] m, im;
        logic [WIDTH-1:0] a, b;
        logic [WIDTH+2:0] e;
        acc = in_valid && in_ready;
        pp  = out_valid && out_ready;
        y = out_y; m = out_mode; a = in_a; b = in_b; im = in_mode;
        @(posedge clk);
        #1;
        cyc++;
        last_pop = pp;
        last_y   = y;
        if (pp) begin
            n_pop++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result_order: got y=%0d mode=%0d, required no result", y, m);
            end else begin
                e = exp_q.pop_front();
                if ({y, m} !== e) begin
                    errors++;
                    $display("FAIL result_value: got y=%0d mode=%0d, required y=%0d mode=%0d",
                             y, m, e[WIDTH+2:2], e[1:0]);
                end
            end
        end
        if (acc) begin
            exp_q.push_back({ref_y(int'(a), int'(b), int'(im)), im});
            n_acc++;
        end
        checks++;
        if (idle !== (exp_q.size() == 0)) begin
            errors++;
            $display("FAIL idle: got %0b, required %0b (outstanding %0d)", idle,
                     exp_q.size() == 0, exp_q.size());
        end
    endtask

    task automatic test_reset();
        in_valid = 0; in_a = 0; in_b = 0; in_mode = 0; out_ready = 0;
        rstn = 1;
        #2 rstn = 0;
        #1;
        checks++;
        if ({in_ready, alu_a, alu_b, alu_mode, out_valid, out_y, out_mode, idle} !==
            {1'b1, 4'd0, 4'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: got %b, required %b",
                     {in_ready, alu_a, alu_b, alu_mode, out_valid, out_y, out_mode, idle},
                     {1'b1, 4'd0, 4'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b1});
        end
        repeat (2) @(posedge clk);
        #1 rstn = 1;
    endtask

    task automatic test_basic();
        in_valid = 1; in_a = 3; in_b = 5; in_mode = 0;
        tick();
        in_valid = 0;
        tick();
        checks++;
        if ({alu_a, alu_b, alu_mode} !== {4'd3, 4'd5, 2'd0}) begin
            errors++;
            $display("FAIL basic_issue: got a=%0d b=%0d m=%0d, required a=3 b=5 m=0",
                     alu_a, alu_b, alu_mode);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early: got out_valid=%0b, required 0", out_valid);
        end
        tick();
        checks++;
        if ({out_valid, out_y, out_mode} !== {1'b1, 5'd8, 2'd0}) begin
            errors++;
            $display("FAIL basic_result: got v=%0b y=%0d m=%0d, required v=1 y=8 m=0",
                     out_valid, out_y, out_mode);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL basic_idle: got %0b, required 1", idle);
        end
    endtask

    task automatic test_back_to_back();
        int ta[4] = '{2, 15, 0, 15};
        int tb[4] = '{3, 0, 15, 15};
        int tm[4] = '{1, 2, 3, 0};
        int ty[4] = '{31, 16, 16, 30};
        int c0, pops;
        out_ready = 1;
        c0 = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_a = 4'(ta[i]); in_b = 4'(tb[i]); in_mode = 2'(tm[i]);
            tick();
            if (i == 0) c0 = cyc;
        end
        in_valid = 0;
        pops = 0;
        for (int k = 0; k < 20 && pops < 4; k++) begin
            tick();
            if (last_pop) begin
                checks++;
                if (last_y !== 5'(ty[pops]) || cyc != c0 + 4 + pops) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got y=%0d at cycle %0d, required y=%0d at cycle %0d",
                             pops, last_y, cyc, ty[pops], c0 + 4 + pops);
                end
                pops++;
            end
        end
        checks++;
        if (pops != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, required 4", pops);
        end
        out_ready = 0;
    endtask

    task automatic test_backpressure();
        int a0, p0;
        out_ready = 0;
        in_valid = 1;
        a0 = n_acc;
        for (int k = 0; k < 20; k++) begin
            in_a = 4'($urandom); in_b = 4'($urandom); in_mode = 2'($urandom);
            tick();
        end
        checks++;
        if (n_acc - a0 != DEPTH + 4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accepts: got %0d accepts in_ready=%0b, required %0d in_ready=0",
                     n_acc - a0, in_ready, DEPTH + 4);
        end
        in_valid = 0;
        out_ready = 1;
        p0 = n_pop;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
        checks++;
        if (n_pop - p0 != DEPTH + 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: got %0d results (%0d left), required %0d (0 left)",
                     n_pop - p0, exp_q.size(), DEPTH + 4);
        end
        out_ready = 0;
    endtask

    task automatic test_full_toggle();
        out_ready = 0;
        in_valid = 1;
        for (int k = 0; k < 40 + 16; k++) begin
            in_a = 4'($urandom); in_b = 4'($urandom); in_mode = 2'($urandom);
            if (k >= 16) out_ready = ~out_ready;
            tick();
            checks++;
            if (dut.res_count_q > 3'd4) begin
                errors++;
                $display("FAIL full_occupancy: got %0d, required at most 4", dut.res_count_q);
            end
        end
        in_valid = 0;
        out_ready = 1;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_drain: got %0d undelivered, required 0", exp_q.size());
        end
        out_ready = 0;
    endtask

    task automatic test_reset_mid();
        int p0;
        logic [WIDTH:0] got;
        out_ready = 0;
        in_valid = 1;
        for (int k = 0; k < 14; k++) begin
            in_a = 4'($urandom); in_b = 4'($urandom); in_mode = 2'($urandom);
            if (k >= 12) out_ready = 1;
            tick();
        end
        out_ready = 0;
        #2 rstn = 0;
        #1;
        exp_q.delete();
        in_valid = 0;
        checks++;
        if ({in_ready, alu_a, alu_b, alu_mode, out_valid, out_y, out_mode, idle} !==
            {1'b1, 4'd0, 4'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL midreset_values: got %b, required %b",
                     {in_ready, alu_a, alu_b, alu_mode, out_valid, out_y, out_mode, idle},
                     {1'b1, 4'd0, 4'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b1});
        end
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        in_valid = 1; in_a = 1; in_b = 1; in_mode = 0;
        out_ready = 1;
        p0 = n_pop;
        got = '0;
        tick();
        in_valid = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (last_pop) got = last_y;
        end
        checks++;
        if (n_pop - p0 != 1 || got !== 5'd2) begin
            errors++;
            $display("FAIL midreset_after: got %0d results last y=%0d, required 1 result y=2",
                     n_pop - p0, got);
        end
        out_ready = 0;
    endtask

    task automatic test_random();
        int p0, a0;
        p0 = n_pop;
        a0 = n_acc;
        for (int k = 0; k < 10000; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = 4'($urandom);
            in_b      = 4'($urandom);
            in_mode   = 2'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 0;
        out_ready = 1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
        checks++;
        if (exp_q.size() != 0 || (n_pop - p0) != (n_acc - a0)) begin
            errors++;
            $display("FAIL random_drain: got %0d results for %0d accepts (%0d left), required all",
                     n_pop - p0, n_acc - a0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_full_toggle();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
